// File: rtl/mvau_wgen_pkg.sv
// Shared types and constants for the MVAU weight fetch sequencer.
package mvau_wgen_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} wgen_state_t;

    localparam int WGEN_BUF_DEPTH = 2;
    localparam int WGEN_OCC_BW    = $clog2(WGEN_BUF_DEPTH + 1);

endpackage

// File: rtl/mvau_wgen_skid.sv
// Small credit buffer holding captured weight words until the compute stage accepts them.
module mvau_wgen_skid
    import mvau_wgen_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [WGEN_OCC_BW-1:0] occ
);
    localparam int PTR_BW = (WGEN_BUF_DEPTH > 1) ? $clog2(WGEN_BUF_DEPTH) : 1;
    localparam logic [PTR_BW-1:0]      PTR_LAST = PTR_BW'(WGEN_BUF_DEPTH - 1);
    localparam logic [WGEN_OCC_BW-1:0] OCC_FULL = WGEN_OCC_BW'(WGEN_BUF_DEPTH);

    logic [W-1:0]           mem_q [WGEN_BUF_DEPTH];
    logic [W-1:0]           mem_d [WGEN_BUF_DEPTH];
    logic [PTR_BW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WGEN_OCC_BW-1:0] occ_q, occ_d;
    logic                   do_push, do_pop;

    // A push into a full buffer is accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (occ_q != '0);
        do_push = push && ((occ_q != OCC_FULL) || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_BW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_BW'(1);
        end
        occ_d = occ_q + WGEN_OCC_BW'(do_push) - WGEN_OCC_BW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WGEN_BUF_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign head_data = mem_q[rd_q];
    assign occ       = occ_q;

endmodule

// File: rtl/mvau_weight_gen.sv
// Weight fetch sequencer: walks the weight memory, absorbs its read latency and
// streams SIMD*TW words with synapse-fold / tile-end markers under valid/ready.
module mvau_weight_gen
    import mvau_wgen_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int SF           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wgen_en,
    input  logic                    wgen_clr,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic                    wstream_v,
    input  logic                    wstream_rdy,
    output logic [SIMD*TW-1:0]      wstream_data,
    output logic                    wstream_sf_last,
    output logic                    wstream_last
);
    localparam int DW    = SIMD * TW;
    localparam int PW    = DW + 2;
    localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int CR_BW = WGEN_OCC_BW + 1;
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    localparam logic [SF_BW-1:0]        SF_LAST   = SF_BW'(SF - 1);

    if (WMEM_DEPTH % SF != 0) begin : g_bad_depth
        $error("mvau_weight_gen: WMEM_DEPTH must be a multiple of SF");
    end
    if ((2 ** WMEM_ADDR_BW) < WMEM_DEPTH) begin : g_bad_addr_bw
        $error("mvau_weight_gen: WMEM_ADDR_BW too narrow for WMEM_DEPTH");
    end

    typedef struct packed {
        logic sf_last;
        logic last;
    } wtag_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sf_last;
        logic          last;
    } wword_t;

    wgen_state_t            state_q, state_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic [SF_BW-1:0]       sf_q, sf_d;
    logic                   rd_pend_q, rd_pend_d;
    wtag_t                  tag_q, tag_d;

    logic [WGEN_OCC_BW-1:0] occ;
    logic [CR_BW-1:0]       credit;
    logic                   pop, issue;
    wword_t                 head, push_word;

    assign wstream_v = (occ != '0);
    assign pop       = wstream_v && wstream_rdy;

    // Credits count buffered words plus the read in flight, net of this cycle's pop,
    // so a read is only launched when its data is guaranteed a slot on arrival.
    always_comb begin
        credit    = CR_BW'(occ) + CR_BW'(rd_pend_q) - CR_BW'(pop);
        issue     = (state_q == RUN) && (credit < CR_BW'(WGEN_BUF_DEPTH));
        state_d   = state_q;
        addr_d    = addr_q;
        sf_d      = sf_q;
        tag_d     = tag_q;
        rd_pend_d = issue;

        case (state_q)
            IDLE:    if (wgen_en) state_d = RUN;
            RUN:     if (!wgen_en) state_d = DRAIN;
            DRAIN: begin
                if (wgen_en)                          state_d = RUN;
                else if (!rd_pend_q && occ == '0)     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            tag_d.sf_last = (sf_q == SF_LAST);
            tag_d.last    = (addr_q == ADDR_LAST);
            addr_d        = (addr_q == ADDR_LAST) ? '0 : addr_q + WMEM_ADDR_BW'(1);
            sf_d          = (sf_q == SF_LAST) ? '0 : sf_q + SF_BW'(1);
        end else if (state_q == IDLE && wgen_clr) begin
            addr_d = '0;
            sf_d   = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sf_q      <= '0;
            rd_pend_q <= 1'b0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sf_q      <= sf_d;
            rd_pend_q <= rd_pend_d;
            tag_q     <= tag_d;
        end
    end

    assign push_word = '{data: wmem_in, sf_last: tag_q.sf_last, last: tag_q.last};

    mvau_wgen_skid #(
        .W (PW)
    ) u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (rd_pend_q),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head),
        .occ       (occ)
    );

    assign wmem_addr       = addr_q;
    assign wstream_data    = head.data;
    assign wstream_sf_last = head.sf_last;
    assign wstream_last    = head.last;

endmodule

// File: tb/tb_mvau_weight_gen.sv
// Scoreboard bench for mvau_weight_gen: stimulus queues expected words, a monitor
// pops and compares each accepted beat.
module tb_mvau_weight_gen;

    logic       aclk;
    logic       aresetn;
    logic       wgen_en;
    logic       wgen_clr;
    logic [3:0] wmem_addr;
    logic [1:0] wmem_in;
    logic       wstream_v;
    logic       wstream_rdy;
    logic [1:0] wstream_data;
    logic       wstream_sf_last;
    logic       wstream_last;

    mvau_weight_gen #(
        .SIMD(2), .TW(1), .SF(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .wgen_en         (wgen_en),
        .wgen_clr        (wgen_clr),
        .wmem_addr       (wmem_addr),
        .wmem_in         (wmem_in),
        .wstream_v       (wstream_v),
        .wstream_rdy     (wstream_rdy),
        .wstream_data    (wstream_data),
        .wstream_sf_last (wstream_sf_last),
        .wstream_last    (wstream_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Weight memory preloaded 0,1,2,3 with a registered read port.
    logic [1:0] wmem [4];
    initial for (int i = 0; i < 4; i++) wmem[i] = 2'(i);
    always @(posedge aclk) wmem_in <= wmem[wmem_addr[1:0]];

    typedef struct {
        logic [1:0] data;
        logic       sf_last;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   delivered = 0;
    int   issued = 0;
    logic [3:0] prev_addr = '0;
    bit   track_inflight = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected stream restarting at address 0: data = address, sf_last on odd, last on 3.
    task automatic sb_restart();
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 2100; i++) begin
            e.data    = 2'(i % 4);
            e.sf_last = (i % 2) == 1;
            e.last    = (i % 4) == 3;
            exp_q.push_back(e);
        end
        delivered = 0;
        issued    = 0;
        prev_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn     = 1'b0;
        wgen_en     = 1'b0;
        wgen_clr    = 1'b0;
        wstream_rdy = 1'b1;
        sb_restart();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input int max_cyc);
        int k;
        k = 0;
        while (delivered < n && k < max_cyc) begin
            @(negedge aclk);
            k++;
        end
        if (delivered < n) chk("deliv_timeout", 32'(delivered), 32'(n));
    endtask

    // Monitor: samples after inputs settle, i.e. exactly what the DUT sees at the next edge.
    always @(negedge aclk) begin
        exp_t e;
        #1;
        if (aresetn) begin
            if (track_inflight) begin
                if (wmem_addr != prev_addr) issued++;
                prev_addr = wmem_addr;
                n_cmp++;
                if (issued - delivered > 2) begin
                    n_err++;
                    $display("FAIL inflight: got %0d, expected <= 2", issued - delivered);
                end
            end
            if (wstream_v && wstream_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got word %0d, expected none", wstream_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("data",    32'(wstream_data),    32'(e.data));
                    chk("sf_last", 32'(wstream_sf_last), 32'(e.sf_last));
                    chk("last",    32'(wstream_last),    32'(e.last));
                end
                delivered++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn     = 1'b0;
        wgen_en     = 1'b0;
        wgen_clr    = 1'b0;
        wstream_rdy = 1'b1;
        sb_restart();
        #12;
        chk("rst_v",       32'(wstream_v),       0);
        chk("rst_data",    32'(wstream_data),    0);
        chk("rst_sf_last", 32'(wstream_sf_last), 0);
        chk("rst_last",    32'(wstream_last),    0);
        chk("rst_addr",    32'(wmem_addr),       0);

        // Latency and full rate.
        @(negedge aclk);
        aresetn = 1'b1;
        wgen_en = 1'b1;
        @(negedge aclk);
        chk("lat_e0_v", 32'(wstream_v), 0);
        @(negedge aclk);
        chk("lat_e1_v", 32'(wstream_v), 0);
        chk("lat_e1_addr", 32'(wmem_addr), 1);
        @(negedge aclk);
        chk("lat_e2_v", 32'(wstream_v), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("fullrate_v", 32'(wstream_v), 1);
        end
        chk("fullrate_cnt", 32'(delivered), 5);
        wgen_en = 1'b0;
        repeat (6) @(negedge aclk);

        // Backpressure after word 1.
        do_reset();
        wgen_en = 1'b1;
        wait_deliv(2, 20);
        wstream_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge aclk);
            chk("stall_v",    32'(wstream_v),    1);
            chk("stall_data", 32'(wstream_data), 2);
            chk("stall_addr", 32'(wmem_addr),    0);
        end
        wstream_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("resume_v", 32'(wstream_v), 1);
        end
        chk("resume_cnt", 32'(delivered), 5);
        wgen_en = 1'b0;
        repeat (6) @(negedge aclk);

        // Disable so that addr 2 is the last read issued; re-enable resumes at 3.
        do_reset();
        wgen_en = 1'b1;
        repeat (3) @(negedge aclk);
        wgen_en = 1'b0;
        repeat (8) @(negedge aclk);
        chk("drain_cnt",  32'(delivered), 3);
        chk("drain_v",    32'(wstream_v), 0);
        chk("drain_addr", 32'(wmem_addr), 3);
        wgen_en = 1'b1;
        wait_deliv(7, 30);
        wgen_en = 1'b0;
        repeat (8) @(negedge aclk);
        chk("drain2_v", 32'(wstream_v), 0);

        // Clear in IDLE with the SF counter mid-group; clear in RUN is ignored.
        do_reset();
        wgen_en = 1'b1;
        @(negedge aclk);
        wgen_en = 1'b0;
        repeat (8) @(negedge aclk);
        chk("clr_pre_cnt",  32'(delivered), 1);
        chk("clr_pre_addr", 32'(wmem_addr), 1);
        wgen_clr = 1'b1;
        @(negedge aclk);
        wgen_clr = 1'b0;
        chk("clr_idle_addr", 32'(wmem_addr), 0);
        sb_restart();
        wgen_en = 1'b1;
        wait_deliv(3, 20);
        wgen_clr = 1'b1;
        @(negedge aclk);
        wgen_clr = 1'b0;
        wait_deliv(9, 30);
        wgen_en = 1'b0;
        repeat (8) @(negedge aclk);
        chk("clr_run_v", 32'(wstream_v), 0);

        // Asynchronous reset mid-stream.
        do_reset();
        wgen_en = 1'b1;
        wait_deliv(3, 20);
        #3;
        aresetn = 1'b0;
        #1;
        chk("arst_v",       32'(wstream_v),       0);
        chk("arst_data",    32'(wstream_data),    0);
        chk("arst_sf_last", 32'(wstream_sf_last), 0);
        chk("arst_last",    32'(wstream_last),    0);
        chk("arst_addr",    32'(wmem_addr),       0);
        sb_restart();
        @(negedge aclk);
        aresetn = 1'b1;
        wait_deliv(6, 30);
        wgen_en = 1'b0;
        repeat (8) @(negedge aclk);

        // Random enable / ready.
        do_reset();
        track_inflight = 1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge aclk);
            wstream_rdy = ($urandom_range(0, 3) != 0);
            wgen_en     = ($urandom_range(0, 7) != 0);
        end
        @(negedge aclk);
        wgen_en     = 1'b0;
        wstream_rdy = 1'b1;
        repeat (10) @(negedge aclk);
        chk("rand_final_v", 32'(wstream_v), 0);
        chk("rand_no_loss", 32'(delivered), 32'(issued));
        track_inflight = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
